// File: rtl/dac_ramp_sequencer.sv
// Per-slave DAC command sequencer: immediate writes or stepped ramps toward a target code, one write per dwell window.
// Latency: command accepted in cycle N gives a new_reg pulse in cycle N+1; later ramp writes follow every dwell_cycles.
// Backpressure: cmd_ready drops for a slave while it is busy (WRITE/DWELL); out-of-range slave commands are always taken and dropped.
module dac_ramp_sequencer #(
  parameter int spi_slaves   = 2,
  parameter int spi_length   = 16,
  parameter int data_bits    = 12,
  parameter int ramp_step    = 16,
  parameter int dwell_cycles = 640,
  localparam int slv_w = (spi_slaves > 1) ? $clog2(spi_slaves) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [slv_w-1:0]                      cmd_slave,
  input  logic                                  cmd_ramp,
  input  logic [spi_length-1:0]                 cmd_data,
  output logic [spi_slaves-1:0]                 new_reg,
  output logic [spi_slaves-1:0][spi_length-1:0] spi_data,
  output logic [spi_slaves-1:0]                 busy,
  output logic [spi_slaves-1:0]                 ramp_done
);

  localparam int hdr_w = spi_length - data_bits;
  localparam int cnt_w = (dwell_cycles > 2) ? $clog2(dwell_cycles) : 1;
  localparam logic [data_bits:0] step_max = (data_bits + 1)'(ramp_step);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DWELL} state_e;

  state_e                                state_q [spi_slaves];
  state_e                                state_d [spi_slaves];
  logic [hdr_w-1:0]                      hdr_q   [spi_slaves];
  logic [hdr_w-1:0]                      hdr_d   [spi_slaves];
  logic [data_bits-1:0]                  tgt_q   [spi_slaves];
  logic [data_bits-1:0]                  tgt_d   [spi_slaves];
  logic [data_bits-1:0]                  cur_q   [spi_slaves];
  logic [data_bits-1:0]                  cur_d   [spi_slaves];
  logic [cnt_w-1:0]                      cnt_q   [spi_slaves];
  logic [cnt_w-1:0]                      cnt_d   [spi_slaves];
  logic [spi_slaves-1:0]                 ramp_q, ramp_d;
  logic [spi_slaves-1:0]                 done_q, done_d;
  logic [spi_slaves-1:0][spi_length-1:0] spi_data_q, spi_data_d;

  logic in_range;
  logic accept;

  // Next code toward tgt: full jump for immediate writes, otherwise at most ramp_step without overshoot.
  function automatic logic [data_bits-1:0] next_code(input logic [data_bits-1:0] cur,
                                                      input logic [data_bits-1:0] tgt,
                                                      input logic             ramp);
    logic [data_bits:0]   diff;
    logic [data_bits:0]   step;
    logic [data_bits-1:0] res;
    res = tgt;
    if (ramp && (tgt > cur)) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      step = (diff > step_max) ? step_max : diff;
      res  = cur + step[data_bits-1:0];
    end else if (ramp && (tgt < cur)) begin
      diff = {1'b0, cur} - {1'b0, tgt};
      step = (diff > step_max) ? step_max : diff;
      res  = cur - step[data_bits-1:0];
    end
    return res;
  endfunction

  // Busy status and command handshake; ready only looks at the addressed slave.
  always_comb begin
    for (int s = 0; s < spi_slaves; s++) begin
      busy[s]    = (state_q[s] != ST_IDLE);
      new_reg[s] = (state_q[s] == ST_WRITE);
    end
    in_range  = ({1'b0, cmd_slave} < (slv_w + 1)'(spi_slaves));
    cmd_ready = !rst && (!in_range || !busy[cmd_slave]);
    accept    = cmd_valid && cmd_ready;
  end

  assign spi_data  = spi_data_q;
  assign ramp_done = done_q;

  // Per-slave next-state: the output word and cur are loaded on entry to WRITE so the pulse and data coincide.
  always_comb begin
    spi_data_d = spi_data_q;
    ramp_d     = ramp_q;
    done_d     = '0;
    for (int s = 0; s < spi_slaves; s++) begin
      state_d[s] = state_q[s];
      hdr_d[s]   = hdr_q[s];
      tgt_d[s]   = tgt_q[s];
      cur_d[s]   = cur_q[s];
      cnt_d[s]   = cnt_q[s];
      case (state_q[s])
        ST_IDLE: begin
          if (accept && in_range && (cmd_slave == slv_w'(s))) begin
            hdr_d[s]      = cmd_data[spi_length-1:data_bits];
            tgt_d[s]      = cmd_data[data_bits-1:0];
            ramp_d[s]     = cmd_ramp;
            cur_d[s]      = next_code(cur_q[s], cmd_data[data_bits-1:0], cmd_ramp);
            spi_data_d[s] = {cmd_data[spi_length-1:data_bits], cur_d[s]};
            state_d[s]    = ST_WRITE;
          end
        end
        ST_WRITE: begin
          // WRITE itself is the first cycle of the dwell window.
          cnt_d[s]   = cnt_w'(dwell_cycles - 2);
          state_d[s] = ST_DWELL;
        end
        ST_DWELL: begin
          if (cnt_q[s] != '0) begin
            cnt_d[s] = cnt_q[s] - 1'b1;
          end else if (cur_q[s] == tgt_q[s]) begin
            done_d[s]  = 1'b1;
            state_d[s] = ST_IDLE;
          end else begin
            cur_d[s]      = next_code(cur_q[s], tgt_q[s], ramp_q[s]);
            spi_data_d[s] = {hdr_q[s], cur_d[s]};
            state_d[s]    = ST_WRITE;
          end
        end
        default: state_d[s] = ST_IDLE;
      endcase
    end
  end

  // State registers; reset aborts any ramp or dwell immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_data_q <= '0;
      ramp_q     <= '0;
      done_q     <= '0;
      for (int s = 0; s < spi_slaves; s++) begin
        state_q[s] <= ST_IDLE;
        hdr_q[s]   <= '0;
        tgt_q[s]   <= '0;
        cur_q[s]   <= '0;
        cnt_q[s]   <= '0;
      end
    end else begin
      spi_data_q <= spi_data_d;
      ramp_q     <= ramp_d;
      done_q     <= done_d;
      for (int s = 0; s < spi_slaves; s++) begin
        state_q[s] <= state_d[s];
        hdr_q[s]   <= hdr_d[s];
        tgt_q[s]   <= tgt_d[s];
        cur_q[s]   <= cur_d[s];
        cnt_q[s]   <= cnt_d[s];
      end
    end
  end

endmodule

// File: tb/tb_dac_ramp_sequencer.sv
// Scoreboard bench for dac_ramp_sequencer: stimulus pushes expected pulses per slave, a monitor pops and checks.
module tb_dac_ramp_sequencer;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [0:0]       cmd_slave;
  logic             cmd_ramp;
  logic [15:0]      cmd_data;
  logic [1:0]       new_reg;
  logic [1:0][15:0] spi_data;
  logic [1:0]       busy;
  logic [1:0]       ramp_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    bit          done;
    logic [15:0] dat;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  dac_ramp_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_slave (cmd_slave),
    .cmd_ramp  (cmd_ramp),
    .cmd_data  (cmd_data),
    .new_reg   (new_reg),
    .spi_data  (spi_data),
    .busy      (busy),
    .ramp_done (ramp_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push_ev(int s, int c, bit dn, logic [15:0] d);
    ev_t e;
    e.cyc = c; e.done = dn; e.dat = d;
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // n write pulses spaced 640 cycles from acc+1, then the done pulse one dwell after the last.
  function automatic void exp_seq(int s, int acc, int n, logic [15:0] w0, logic [15:0] w1,
                                  logic [15:0] w2, logic [15:0] w3);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      case (i)
        0:       w = w0;
        1:       w = w1;
        2:       w = w2;
        default: w = w3;
      endcase
      push_ev(s, acc + 1 + 640 * i, 1'b0, w);
    end
    push_ev(s, acc + 1 + 640 * n, 1'b1, 16'h0);
  endfunction

  // Monitor: every pulse must match the head of that slave's expectation queue.
  always @(negedge clk) begin
    ev_t e;
    bit  got;
    if (rst === 1'b0) begin
      for (int s = 0; s < 2; s++) begin
        if (new_reg[s] || ramp_done[s]) begin
          got = 1'b0;
          if (s == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
          if (s == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
          if (!got) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_pulse slave%0d cycle %0d: new_reg=%b ramp_done=%b, none expected",
                     s, cyc, new_reg[s], ramp_done[s]);
          end else begin
            check($sformatf("pulse_kind_s%0d", s), {30'd0, new_reg[s], ramp_done[s]},
                  e.done ? 32'd1 : 32'd2);
            check($sformatf("pulse_cycle_s%0d", s), cyc, e.cyc);
            if (!e.done) check($sformatf("pulse_data_s%0d", s), {16'd0, spi_data[s]}, {16'd0, e.dat});
          end
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge following acceptance.
  task automatic send(input int s, input bit rmp, input logic [15:0] d, output int acc, output bit rdy0);
    cmd_valid = 1'b1; cmd_slave = s[0:0]; cmd_ramp = rmp; cmd_data = d;
    acc = -1;
    @(negedge clk);
    rdy0 = cmd_ready;
    for (int t = 0; t < 4000; t++) begin
      if (cmd_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 6000; t++) begin
      if (q0.size() == 0 && q1.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    check("drain_complete", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int acc, a0, a1, a2;
    bit rdy;

    rst = 1'b1; cmd_valid = 1'b0; cmd_slave = 1'b0; cmd_ramp = 1'b0; cmd_data = 16'h0;

    // Reset state and cmd_ready low while in reset.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_outputs", {26'd0, new_reg, busy, ramp_done}, 32'd0);
      check("rst_spi_data", spi_data, 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Immediate write on slave0.
    send(0, 1'b0, 16'h3ABC, acc, rdy);
    exp_seq(0, acc, 1, 16'h3ABC, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    check("imm_busy_first", {30'd0, busy}, 32'd1);
    wait_cyc(acc + 640);
    check("imm_busy_last", {30'd0, busy}, 32'd1);
    @(negedge clk);
    check("imm_busy_clear", {30'd0, busy}, 32'd0);
    check("imm_ready_after_done", {31'd0, cmd_ready}, 32'd1);
    drain();

    // Ramp up on slave1 from 0.
    send(1, 1'b1, 16'h1040, acc, rdy);
    exp_seq(1, acc, 4, 16'h1010, 16'h1020, 16'h1030, 16'h1040);
    drain();

    // Ramp down to a non-multiple of the step.
    send(1, 1'b1, 16'h1005, acc, rdy);
    exp_seq(1, acc, 4, 16'h1030, 16'h1020, 16'h1010, 16'h1005);
    drain();

    // Two slaves on adjacent cycles, then a held slave0 command.
    send(0, 1'b1, 16'h2AF0, a0, rdy);
    exp_seq(0, a0, 4, 16'h2ACC, 16'h2ADC, 16'h2AEC, 16'h2AF0);
    send(1, 1'b1, 16'h5000, a1, rdy);
    exp_seq(1, a1, 1, 16'h5000, 16'h0, 16'h0, 16'h0);
    check("adjacent_accept", a1, a0 + 1);
    send(0, 1'b0, 16'h7123, a2, rdy);
    check("held_ready_low", {31'd0, rdy}, 32'd0);
    check("held_accept_at_done", a2, a0 + 1 + 4 * 640);
    exp_seq(0, a2, 1, 16'h7123, 16'h0, 16'h0, 16'h0);
    drain();

    // Reset in the dwell after the second ramp write.
    send(1, 1'b1, 16'h3040, acc, rdy);
    push_ev(1, acc + 1, 1'b0, 16'h3010);
    push_ev(1, acc + 641, 1'b0, 16'h3020);
    wait_cyc(acc + 700);
    @(posedge clk); #1;
    check("pre_rst_queue_empty", q1.size(), 32'd0);
    rst = 1'b1;
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    check("midrst_spi_data", spi_data, 32'd0);
    check("midrst_busy", {30'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    send(1, 1'b1, 16'h3020, acc, rdy);
    exp_seq(1, acc, 2, 16'h3010, 16'h3020, 16'h0, 16'h0);
    drain();

    // Ramp to the current code: a single write.
    send(1, 1'b1, 16'h4020, acc, rdy);
    exp_seq(1, acc, 1, 16'h4020, 16'h0, 16'h0, 16'h0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
